// File: rtl/data_memory_pipelined_if.sv
// Request/response bus of the pipelined data memory: valid/ready request in,
// fixed-latency read response out (no response backpressure).
interface data_memory_pipelined_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    write;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]   value_in;
    logic [DATA_WIDTH/8-1:0] byte_enable;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   value_out;

    modport master (
        output req_valid, write, address, value_in, byte_enable,
        input  req_ready, rsp_valid, value_out
    );

    modport slave (
        input  req_valid, write, address, value_in, byte_enable,
        output req_ready, rsp_valid, value_out
    );
endinterface

// File: rtl/data_memory_pipelined.sv
// Pipelined byte-lane data memory: hardware zero sweep after reset, then one request/cycle,
// reads respond READ_LATENCY edges after acceptance. Optional fault capture under DMEM_FAULT_EN.
module data_memory_pipelined #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    data_memory_pipelined_if.slave mem_bus,
    output logic                  busy_o
`ifdef DMEM_FAULT_EN
    ,
    output logic                  fault_flag_o,
    output logic [ADDR_WIDTH-1:0] fault_address_o,
    input  logic                  fault_clear_i
`endif
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic                   clr_we;
    logic                   ready;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic                   s_vld_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]  s_dat_q [READ_LATENCY];
    logic                   rsp_valid_q;
    logic [DATA_WIDTH-1:0]  value_out_q;

    logic                   in_range;
    logic [IDX_W-1:0]       idx;
    logic                   accept;
    logic                   acc_wr;
    logic                   acc_rd;
    logic [DATA_WIDTH-1:0]  rd_dat;

    // Widened compare so DEPTH == 2**ADDR_WIDTH is representable.
    assign in_range = ({1'b0, mem_bus.address} < (ADDR_WIDTH+1)'(DEPTH));
    assign idx      = mem_bus.address[IDX_W-1:0];
    assign accept   = mem_bus.req_valid && ready && reset_n_i;
    assign acc_wr   = accept && mem_bus.write && in_range;
    assign acc_rd   = accept && !mem_bus.write;
    assign rd_dat   = in_range ? mem_q[idx] : '0;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        ready     = 1'b0;
        busy_o    = 1'b1;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                ready  = 1'b1;
                busy_o = 1'b0;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    assign mem_bus.req_ready = ready;

    // Array has no reset; the sweep owns initialisation.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && clr_we) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (acc_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (mem_bus.byte_enable[i]) begin
                    mem_q[idx][8*i +: 8] <= mem_bus.value_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                s_vld_q[i] <= 1'b0;
                s_dat_q[i] <= '0;
            end
            rsp_valid_q <= 1'b0;
            value_out_q <= '0;
        end else begin
            s_vld_q[0] <= acc_rd;
            s_dat_q[0] <= rd_dat;
            for (int i = 1; i < READ_LATENCY; i++) begin
                s_vld_q[i] <= s_vld_q[i-1];
                s_dat_q[i] <= s_dat_q[i-1];
            end
            rsp_valid_q <= s_vld_q[READ_LATENCY-1];
            if (s_vld_q[READ_LATENCY-1]) begin
                value_out_q <= s_dat_q[READ_LATENCY-1];
            end
        end
    end

    assign mem_bus.rsp_valid = rsp_valid_q;
    assign mem_bus.value_out = value_out_q;

`ifdef DMEM_FAULT_EN
    logic                  fault_flag_q;
    logic [ADDR_WIDTH-1:0] fault_addr_q;
    logic                  fault_hit;

    assign fault_hit = accept && !in_range;

    // A new fault beats a simultaneous clear and then records its address.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            fault_flag_q <= 1'b0;
            fault_addr_q <= '0;
        end else if (fault_hit) begin
            fault_flag_q <= 1'b1;
            if (!fault_flag_q || fault_clear_i) begin
                fault_addr_q <= mem_bus.address;
            end
        end else if (fault_clear_i) begin
            fault_flag_q <= 1'b0;
        end
    end

    assign fault_flag_o    = fault_flag_q;
    assign fault_address_o = fault_addr_q;
`endif
endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench for data_memory_pipelined: DEPTH=12, ADDR_WIDTH=4, READ_LATENCY=2, table-driven
// requests with a scoreboard of expected read responses, plus reset and fault sequences.
module tb_data_memory_pipelined;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 12;
    localparam int L     = 2;
    localparam int NV    = 28;

    logic clk;
    logic reset_n;
    logic busy;
`ifdef DMEM_FAULT_EN
    logic          fault_flag;
    logic [AW-1:0] fault_address;
    logic          fault_clear;
`endif

    data_memory_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dif ();

    data_memory_pipelined #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(L)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .mem_bus(dif),
        .busy_o(busy)
`ifdef DMEM_FAULT_EN
        ,
        .fault_flag_o(fault_flag),
        .fault_address_o(fault_address),
        .fault_clear_i(fault_clear)
`endif
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        logic [3:0]    be;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        logic [DW-1:0] dat;
        int            due;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb_q [$];
    int   cyc;
    int   n_checks;
    int   n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every scoreboard entry must be met exactly on its due edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            check("rsp_valid_on_time", 32'(dif.rsp_valid), 32'd1);
            if (dif.rsp_valid) check("rsp_data", dif.value_out, sb_q[0].dat);
            void'(sb_q.pop_front());
        end else if (dif.rsp_valid) begin
            check("rsp_unexpected", 32'(dif.rsp_valid), 32'd0);
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] be, input logic [DW-1:0] exp);
        dif.req_valid   = 1'b1;
        dif.write       = wr;
        dif.address     = a;
        dif.value_in    = d;
        dif.byte_enable = be;
        @(posedge clk);
        #1;
        if (!wr) sb_q.push_back('{exp, cyc + L});
        dif.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic measure_sweep(input string name);
        int n   = 0;
        int bad = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            if (dif.req_ready) bad++;
            n++;
            @(negedge clk);
        end
        check(name, 32'(n), 32'(DEPTH));
        check("ready_low_while_busy", 32'(bad), 32'd0);
        check("ready_after_sweep", 32'(dif.req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_rsp;
        cyc = 0; n_checks = 0; n_errors = 0;
        reset_n = 1'b0;
        dif.req_valid = 1'b0; dif.write = 1'b0; dif.address = '0;
        dif.value_in = '0; dif.byte_enable = '0;
`ifdef DMEM_FAULT_EN
        fault_clear = 1'b0;
`endif
        vecs[0]  = '{1'b1, 4'd5,  32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1]  = '{1'b1, 4'd5,  32'h00000012, 4'h1, 32'h0};
        vecs[2]  = '{1'b0, 4'd5,  32'h0,        4'h0, 32'hDEADBE12};
        vecs[3]  = '{1'b1, 4'd1,  32'h00000011, 4'hF, 32'h0};
        vecs[4]  = '{1'b1, 4'd2,  32'h00000022, 4'hF, 32'h0};
        vecs[5]  = '{1'b1, 4'd3,  32'h00000033, 4'hF, 32'h0};
        vecs[6]  = '{1'b0, 4'd1,  32'h0,        4'h0, 32'h00000011};
        vecs[7]  = '{1'b0, 4'd2,  32'h0,        4'h0, 32'h00000022};
        vecs[8]  = '{1'b0, 4'd3,  32'h0,        4'h0, 32'h00000033};
        vecs[9]  = '{1'b1, 4'd7,  32'hA5A5A5A5, 4'hF, 32'h0};
        vecs[10] = '{1'b0, 4'd7,  32'h0,        4'h0, 32'hA5A5A5A5};
        vecs[11] = '{1'b0, 4'd7,  32'h0,        4'h0, 32'hA5A5A5A5};
        vecs[12] = '{1'b0, 4'd3,  32'h0,        4'h0, 32'h00000033};
        vecs[13] = '{1'b1, 4'd3,  32'hFFFFFFFF, 4'hC, 32'h0};
        vecs[14] = '{1'b0, 4'd3,  32'h0,        4'h0, 32'hFFFF0033};
        vecs[15] = '{1'b1, 4'd4,  32'h12345678, 4'h0, 32'h0};
        vecs[16] = '{1'b0, 4'd4,  32'h0,        4'h0, 32'h00000000};
        vecs[17] = '{1'b1, 4'd9,  32'hCAFEF00D, 4'h6, 32'h0};
        vecs[18] = '{1'b0, 4'd9,  32'h0,        4'h0, 32'h00FEF000};
        vecs[19] = '{1'b0, 4'd11, 32'h0,        4'h0, 32'h00000000};
        vecs[20] = '{1'b1, 4'd11, 32'h76543210, 4'hF, 32'h0};
        vecs[21] = '{1'b0, 4'd11, 32'h0,        4'h0, 32'h76543210};
        vecs[22] = '{1'b1, 4'd13, 32'h000000FF, 4'hF, 32'h0};
        vecs[23] = '{1'b0, 4'd14, 32'h0,        4'h0, 32'h00000000};
        vecs[24] = '{1'b0, 4'd13, 32'h0,        4'h0, 32'h00000000};
        vecs[25] = '{1'b1, 4'd0,  32'hAAAAAAAA, 4'h8, 32'h0};
        vecs[26] = '{1'b0, 4'd0,  32'h0,        4'h0, 32'hAA000000};
        vecs[27] = '{1'b0, 4'd1,  32'h0,        4'h0, 32'h00000011};

        // Reset for two edges, then the sweep.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_req_ready", 32'(dif.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(dif.rsp_valid), 32'd0);
        check("rst_value_out", dif.value_out, 32'h0);
`ifdef DMEM_FAULT_EN
        check("rst_fault_flag", 32'(fault_flag), 32'd0);
        check("rst_fault_addr", 32'(fault_address), 32'd0);
`endif
        reset_n = 1'b1;
        measure_sweep("sweep_len");

        for (int a = 0; a < DEPTH; a++) issue(1'b0, AW'(a), '0, 4'h0, 32'h0);
        drain();

        for (int i = 0; i < NV; i++) issue(vecs[i].wr, vecs[i].addr, vecs[i].dat, vecs[i].be, vecs[i].exp);
        drain();

`ifdef DMEM_FAULT_EN
        check("fault_flag_set", 32'(fault_flag), 32'd1);
        check("fault_first_addr", 32'(fault_address), 32'd13);
        fault_clear = 1'b1;
        @(posedge clk);
        #1;
        fault_clear = 1'b0;
        check("fault_cleared", 32'(fault_flag), 32'd0);
        check("fault_addr_kept", 32'(fault_address), 32'd13);
        issue(1'b0, 4'd14, '0, 4'h0, 32'h0);
        check("fault_reset_flag", 32'(fault_flag), 32'd1);
        check("fault_reset_addr", 32'(fault_address), 32'd14);
        fault_clear = 1'b1;
        issue(1'b0, 4'd15, '0, 4'h0, 32'h0);
        fault_clear = 1'b0;
        check("fault_vs_clear_flag", 32'(fault_flag), 32'd1);
        check("fault_vs_clear_addr", 32'(fault_address), 32'd15);
        issue(1'b1, 4'd12, 32'h1, 4'hF, 32'h0);
        check("fault_sticky_addr", 32'(fault_address), 32'd15);
        drain();
`endif

        // Leave a non-zero value on value_out before the mid-flight reset.
        issue(1'b0, 4'd7, '0, 4'h0, 32'hA5A5A5A5);
        drain();

        dif.req_valid = 1'b1; dif.write = 1'b0; dif.address = 4'd7;
        @(posedge clk);
        #1;
        dif.req_valid = 1'b0;
        reset_n = 1'b0;
        n_rsp = 0;
        repeat (3) begin
            @(negedge clk);
            if (dif.rsp_valid) n_rsp++;
        end
        check("midflight_no_rsp", 32'(n_rsp), 32'd0);
        check("midflight_value_out", dif.value_out, 32'h0);
        check("midflight_busy", 32'(busy), 32'd1);
        check("midflight_req_ready", 32'(dif.req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Interrupt the sweep part-way; it must restart from address 0.
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        measure_sweep("sweep_restart_len");

        issue(1'b0, 4'd7, '0, 4'h0, 32'h0);
        issue(1'b0, 4'd5, '0, 4'h0, 32'h0);
        issue(1'b0, 4'd11, '0, 4'h0, 32'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/data_memory_pipelined.md
Name: data_memory_pipelined

Overview:
Parametrised, pipelined data memory. It generalises the single-word, combinational-read data memory into a block with configurable width and depth, byte-lane writes, registered reads with fixed latency, and a valid/ready request handshake. After reset a hardware clear sweep zeroes the whole array, so memory contents no longer come from a file. It sits between the execute/memory stage and the register write-back path.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 10, word-address width.
DEPTH, 1024, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
READ_LATENCY, 1, cycles from read acceptance to response; legal values are 1 or 2.

Ports:
_CLK  input  1  clock; all state updates on the rising edge.
_RESET_N  input  1  synchronous, active-low reset.
_reqValid  input  1  request present.
reqReady  output  1  block can accept a request this cycle.
_write  input  1  1 = write, 0 = read; sampled with the request.
_address  input  ADDR_WIDTH  word address.
_valueIn  input  DATA_WIDTH  write data.
_byteEnable  input  DATA_WIDTH/8  write lane mask; bit i selects bits [8i+7:8i].
rspValid  output  1  one-cycle pulse marking read data valid.
valueOut  output  DATA_WIDTH  read data.
busy  output  1  clear sweep in progress.
faultFlag  output  1  sticky out-of-range flag (DMEM_FAULT_EN only).
faultAddress  output  ADDR_WIDTH  address of the first fault (DMEM_FAULT_EN only).
_faultClear  input  1  clears the fault flag (DMEM_FAULT_EN only).

Behaviour:
- Single clock domain, _CLK. Reset is synchronous and active-low on _RESET_N, sampled only on the rising edge of _CLK.
- Reset values: reqReady=0, rspValid=0, valueOut=0, busy=1, faultFlag=0, faultAddress=0. All read-pipeline stages are invalidated.
- FSM states:
  - CLEAR: entered on reset. The clear counter starts at 0. Each cycle it writes word[counter]=0 and increments. When the counter reaches DEPTH-1, that word is written and the FSM moves to READY. The sweep takes exactly DEPTH cycles after reset deasserts. During CLEAR, busy=1 and reqReady=0, and _reqValid is ignored.
  - READY: busy=0 and reqReady=1 every cycle (no internal stalls).
- Request acceptance: a request is accepted on a rising edge where _reqValid && reqReady. The block accepts one request per cycle, fully pipelined.
- Write path:
  - On acceptance with _write=1, enabled byte lanes of word[_address] update at that edge. Disabled lanes keep their value.
  - A write never produces rspValid.
  - _byteEnable=0 is a legal no-op.
- Read path:
  - On acceptance with _write=0, rspValid pulses high for exactly one cycle, READY_LATENCY edges later (i.e. READ_LATENCY rising edges after acceptance). valueOut carries word[_address] as it stood after any write accepted on an earlier edge.
  - valueOut holds the last response until the next response. It does not return to 0 when rspValid drops.
  - There is no response backpressure; the consumer must take data while rspValid=1.
- Ordering and hazards:
  - Read-after-write to the same address in the next cycle returns the new data.
  - A read accepted N cycles before a write to the same address returns the old data.
  - Responses leave in acceptance order.
- Out-of-range address (_address >= DEPTH): a write is dropped; a read still responds on schedule with valueOut=0.
- Reset mid-operation:
  - In-flight reads are discarded; no rspValid appears.
  - The CLEAR sweep restarts from address 0, including when reset hits during an ongoing sweep.
- Back-to-back reads at the same address yield consecutive rspValid pulses with identical data.

Optional Feature:
DMEM_FAULT_EN
- Defined:
  - faultFlag, faultAddress and _faultClear exist.
  - An accepted request with _address >= DEPTH sets faultFlag on the next edge. faultAddress captures that address only if faultFlag was 0, so the first fault is kept.
  - _faultClear=1 clears faultFlag on the next edge. If a new fault arrives in the same cycle, the fault wins and faultAddress updates.
  - Reset clears both faultFlag and faultAddress.
- Undefined: the three ports are absent. Out-of-range behaviour is otherwise identical: writes are dropped and reads return 0.

Test Plan:
- Clear sweep: DEPTH=16, deassert _RESET_N after 2 cycles -> busy=1 and reqReady=0 for exactly 16 cycles, then reqReady=1. A read of every address 0..15 returns 0.
- Byte-lane write then read: write 0xDEADBEEF to address 5 with _byteEnable=4'b1111, then write 0x00000012 with _byteEnable=4'b0001, then read address 5 -> rspValid after READ_LATENCY, valueOut=0xDEADBE12.
- Pipelined reads: preload addresses 1,2,3 with 0x11,0x22,0x33, issue reads on 3 consecutive cycles, READ_LATENCY=2 -> rspValid high 3 consecutive cycles starting 2 edges after the first acceptance, values 0x11,0x22,0x33 in order.
- RAW hazard: write 0xA5A5A5A5 to address 7, read address 7 in the next cycle -> valueOut=0xA5A5A5A5.
- Reset mid-flight: issue a read with READ_LATENCY=2, assert _RESET_N=0 on the following edge -> no rspValid pulse, valueOut=0, busy=1, and the sweep restarts for DEPTH cycles.
- Fault (DMEM_FAULT_EN, DEPTH=12, ADDR_WIDTH=4): write 0xFF to address 13, then read address 14 -> faultFlag=1, faultAddress=13, read returns 0. Pulse _faultClear -> faultFlag=0 on the next edge.
